// File: rtl/seg7_if.sv
// Multiplexed 7-segment bus plus the decoded-word output port.
// SEG7_DP_EN adds the decimal point input (dp) and its decoded output (out_dp).
// Valid/ready: a word moves on a rising edge where out_valid && out_ready.
// While out_valid is high, out_value/out_err (and out_dp) stay stable.
interface seg7_if #(parameter int NDIG = 4);
  logic [NDIG-1:0]   an;
  logic [6:0]        a_to_g;
  logic [4*NDIG-1:0] out_value;
  logic [NDIG-1:0]   out_err;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
`ifdef SEG7_DP_EN
  logic              dp;
  logic [NDIG-1:0]   out_dp;

  modport master (output an, a_to_g, dp, out_ready,
                  input  out_value, out_err, out_dp, out_valid, overrun);
  modport slave  (input  an, a_to_g, dp, out_ready,
                  output out_value, out_err, out_dp, out_valid, overrun);
`else
  modport master (output an, a_to_g, out_ready,
                  input  out_value, out_err, out_valid, overrun);
  modport slave  (input  an, a_to_g, out_ready,
                  output out_value, out_err, out_valid, overrun);
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment display bus.
// Samples the active-low digit enables and segments, then waits for each digit
// to dwell long enough. It decodes each stable digit back to a nibble and
// assembles one NDIG-digit word per scan frame.
// Optional feature macro: SEG7_DP_EN (decimal point input dp / output out_dp).
module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input logic   clk,
  input logic   clr,
  seg7_if.slave bus
);
  localparam int CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYC - 2);

  logic [NDIG-1:0]   an_r, an_p;
  logic [6:0]        seg_r, seg_p;
  logic [CW-1:0]     cnt;
  logic              done;
  logic [NDIG-1:0]   seen;
  logic [4*NDIG-1:0] slots;
  logic [NDIG-1:0]   slot_err;
  logic [4*NDIG-1:0] value_q;
  logic [NDIG-1:0]   err_q;
  logic              valid_q, overrun_q;
  logic              legal, same, cap, frame_done;
  logic [3:0]        dec_nib;
  logic              dec_bad;
`ifdef SEG7_DP_EN
  logic              dp_r, dp_p;
  logic [NDIG-1:0]   slot_dp, dp_q;
`endif

  // Register the raw bus once and keep the previous sample for the stability compare.
  always_ff @(posedge clk) begin
    if (clr) begin
      an_r  <= '0;
      an_p  <= '0;
      seg_r <= '0;
      seg_p <= '0;
`ifdef SEG7_DP_EN
      dp_r  <= 1'b0;
      dp_p  <= 1'b0;
`endif
    end else begin
      an_r  <= bus.an;
      an_p  <= an_r;
      seg_r <= bus.a_to_g;
      seg_p <= seg_r;
`ifdef SEG7_DP_EN
      dp_r  <= bus.dp;
      dp_p  <= dp_r;
`endif
    end
  end

  // Legal select, dwell stability, and the single capture strobe per dwell.
  always_comb begin
    legal = ($countones(~an_r) == 1);
`ifdef SEG7_DP_EN
    same  = (an_r == an_p) && (seg_r == seg_p) && (dp_r == dp_p);
`else
    same  = (an_r == an_p) && (seg_r == seg_p);
`endif
    cap        = legal && same && !done && (cnt == CNT_CAP);
    frame_done = &seen;
  end

  // Invert the hex -> segment code; unknown patterns decode to 0 and flag an error.
  always_comb begin
    dec_nib = 4'h0;
    dec_bad = 1'b0;
    case (seg_r)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      default:    dec_bad = 1'b1;
    endcase
  end

  // Dwell counter saturates at STABLE_CYC-1; done blocks a second capture in one dwell.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      if (!legal || !same) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (!same) done <= 1'b0;
      else if (cap) done <= 1'b1;
    end
  end

  // Write the captured digit into its slot and track which digits this frame has seen.
  always_ff @(posedge clk) begin
    if (clr) begin
      seen     <= '0;
      slots    <= '0;
      slot_err <= '0;
`ifdef SEG7_DP_EN
      slot_dp  <= '0;
`endif
    end else begin
      seen <= (frame_done ? '0 : seen) | (cap ? ~an_r : '0);
      for (int i = 0; i < NDIG; i++) begin
        if (cap && !an_r[i]) begin
          slots[4*i +: 4] <= dec_nib;
          slot_err[i]     <= dec_bad;
`ifdef SEG7_DP_EN
          slot_dp[i]      <= ~dp_r;
`endif
        end
      end
    end
  end

  // Output word register: load a complete frame when the port is free, else flag overrun.
  always_ff @(posedge clk) begin
    if (clr) begin
      value_q   <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q      <= '0;
`endif
    end else if (frame_done && (!valid_q || bus.out_ready)) begin
      value_q <= slots;
      err_q   <= slot_err;
      valid_q <= 1'b1;
`ifdef SEG7_DP_EN
      dp_q    <= slot_dp;
`endif
    end else begin
      if (frame_done) overrun_q <= 1'b1;
      if (valid_q && bus.out_ready) valid_q <= 1'b0;
    end
  end

  assign bus.out_value = value_q;
  assign bus.out_err   = err_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = overrun_q;
`ifdef SEG7_DP_EN
  assign bus.out_dp    = dp_q;
`endif
endmodule
